// File: rtl/parser_wait_segs.sv
// Parser front end: captures the first C_NUM_SEGS beats of a packet into a flat header vector,
// issues the VLAN ID as the parse-action RAM address and hands the header on with segs_valid.
module parser_wait_segs #(
  parameter int unsigned C_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_NUM_SEGS         = 16,
  parameter int unsigned C_VLANID_WIDTH     = 12,
  parameter int unsigned C_RAM_LAT          = 2
) (
  input  logic                                      axis_clk,
  input  logic                                      aresetn,
  input  logic [C_AXIS_DATA_WIDTH-1:0]              s_axis_tdata,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]             s_axis_tuser,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]            s_axis_tkeep,
  input  logic                                      s_axis_tvalid,
  input  logic                                      s_axis_tlast,
  output logic                                      s_axis_tready,
  output logic [C_NUM_SEGS*C_AXIS_DATA_WIDTH-1:0]   tdata_segs,
  output logic [C_AXIS_TUSER_WIDTH-1:0]             tuser_1st,
  output logic                                      segs_valid,
  input  logic                                      segs_ready,
  output logic [C_VLANID_WIDTH-1:0]                 vlan_id,
  output logic                                      vlan_id_valid
);

  localparam int unsigned IdxW    = $clog2(C_NUM_SEGS);
  localparam int unsigned CntW    = IdxW + 1;
  localparam int unsigned LatW    = $clog2(C_RAM_LAT + 1) + 1;
  localparam int unsigned VlanLsb = 116;

  localparam logic [CntW-1:0] SegLast = CntW'(C_NUM_SEGS - 1);
  localparam logic [LatW-1:0] LatMax  = LatW'(C_RAM_LAT);
  // segs_valid trails EMIT entry by one cycle, so leaving WAIT_RAM one count early still
  // lands the pulse C_RAM_LAT cycles after vlan_id_valid.
  localparam logic [LatW-1:0] LatDone = LatW'(C_RAM_LAT - 1);

  typedef enum logic [2:0] {StIdle, StFill, StWaitRam, StEmit, StDrain} state_e;

  state_e                    state_q, state_d;
  logic [CntW-1:0]           seg_cnt_q, seg_cnt_d;
  logic [LatW-1:0]           lat_cnt_q, lat_cnt_d;
  logic                      drain_pending_q, drain_pending_d;
  logic                      tready_q, tready_d;
  logic                      segs_valid_q, segs_valid_d;
  logic                      vlan_id_valid_q;
  logic [C_VLANID_WIDTH-1:0] vlan_id_q;
  logic [C_AXIS_TUSER_WIDTH-1:0]                    tuser_q;
  logic [C_NUM_SEGS-1:0][C_AXIS_DATA_WIDTH-1:0]     segs_q;

  logic            beat_acc, first_acc, fill_acc;
  logic [IdxW-1:0] seg_idx;
  logic            unused_tkeep;

  assign beat_acc     = s_axis_tvalid && tready_q;
  assign first_acc    = beat_acc && (state_q == StIdle);
  assign fill_acc     = beat_acc && (state_q == StFill);
  assign seg_idx      = seg_cnt_q[IdxW-1:0];
  assign unused_tkeep = ^s_axis_tkeep;

  always_comb begin
    state_d         = state_q;
    seg_cnt_d       = seg_cnt_q;
    drain_pending_d = drain_pending_q;
    segs_valid_d    = 1'b0;
    lat_cnt_d       = (lat_cnt_q == LatMax) ? lat_cnt_q : lat_cnt_q + 1'b1;

    case (state_q)
      StIdle: begin
        if (first_acc) begin
          seg_cnt_d       = CntW'(1);
          lat_cnt_d       = LatW'(1);
          drain_pending_d = 1'b0;
          state_d         = s_axis_tlast ? StWaitRam : StFill;
        end
      end
      StFill: begin
        if (beat_acc) begin
          seg_cnt_d = seg_cnt_q + 1'b1;
          if (s_axis_tlast) begin
            drain_pending_d = 1'b0;
            state_d         = StWaitRam;
          end else if (seg_cnt_q == SegLast) begin
            drain_pending_d = 1'b1;
            state_d         = StWaitRam;
          end
        end
      end
      StWaitRam: begin
        if (lat_cnt_q >= LatDone) begin
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (segs_valid_q) begin
          state_d = drain_pending_q ? StDrain : StIdle;
        end else if (segs_ready) begin
          segs_valid_d = 1'b1;
        end
      end
      StDrain: begin
        if (beat_acc && s_axis_tlast) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign tready_d = (state_d == StIdle) || (state_d == StFill) || (state_d == StDrain);

  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      state_q         <= StIdle;
      seg_cnt_q       <= '0;
      lat_cnt_q       <= '0;
      drain_pending_q <= 1'b0;
      tready_q        <= 1'b0;
      segs_valid_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      seg_cnt_q       <= seg_cnt_d;
      lat_cnt_q       <= lat_cnt_d;
      drain_pending_q <= drain_pending_d;
      tready_q        <= tready_d;
      segs_valid_q    <= segs_valid_d;
    end
  end

  // A first beat wipes every segment so a short packet never inherits stale header data.
  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      segs_q          <= '0;
      tuser_q         <= '0;
      vlan_id_q       <= '0;
      vlan_id_valid_q <= 1'b0;
    end else begin
      vlan_id_valid_q <= first_acc;
      if (first_acc) begin
        segs_q    <= '0;
        segs_q[0] <= s_axis_tdata;
        tuser_q   <= s_axis_tuser;
        vlan_id_q <= s_axis_tdata[VlanLsb +: C_VLANID_WIDTH];
      end else if (fill_acc) begin
        segs_q[seg_idx] <= s_axis_tdata;
      end
    end
  end

  assign s_axis_tready = tready_q;
  assign tdata_segs    = segs_q;
  assign tuser_1st     = tuser_q;
  assign segs_valid    = segs_valid_q;
  assign vlan_id       = vlan_id_q;
  assign vlan_id_valid = vlan_id_valid_q;

endmodule

// File: tb/tb_parser_wait_segs.sv
// Bench for parser_wait_segs: randomized packets checked against a per-packet header model.
module tb_parser_wait_segs;

  localparam int NS = 16;
  localparam int DW = 256;
  localparam int UW = 128;

  typedef logic [NS*DW-1:0] segs_t;
  typedef logic [DW-1:0]    beat_t;

  logic          axis_clk = 1'b0;
  logic          aresetn = 1'b0;
  beat_t         s_axis_tdata = '0;
  logic [UW-1:0] s_axis_tuser = '0;
  logic [DW/8-1:0] s_axis_tkeep = '1;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  segs_t         tdata_segs;
  logic [UW-1:0] tuser_1st;
  logic          segs_valid;
  logic          segs_ready = 1'b1;
  logic [11:0]   vlan_id;
  logic          vlan_id_valid;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  beat_t         pkt[$];
  logic [UW-1:0] pkt_user;

  segs_t         mon_segs[$];
  logic [UW-1:0] mon_user[$];
  logic [11:0]   mon_vlan[$];

  parser_wait_segs dut (
    .axis_clk      (axis_clk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .tdata_segs    (tdata_segs),
    .tuser_1st     (tuser_1st),
    .segs_valid    (segs_valid),
    .segs_ready    (segs_ready),
    .vlan_id       (vlan_id),
    .vlan_id_valid (vlan_id_valid)
  );

  always #5 axis_clk = ~axis_clk;
  always @(posedge axis_clk) cyc <= cyc + 1;

  always @(negedge axis_clk) begin
    if (segs_valid) begin
      mon_segs.push_back(tdata_segs);
      mon_user.push_back(tuser_1st);
    end
    if (vlan_id_valid) mon_vlan.push_back(vlan_id);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required finished");
    $fatal(1);
  end

  function automatic beat_t rand_beat();
    beat_t b;
    for (int k = 0; k < DW / 32; k++) b[k*32 +: 32] = $urandom;
    return b;
  endfunction

  function automatic logic [UW-1:0] rand_user();
    logic [UW-1:0] u;
    for (int k = 0; k < UW / 32; k++) u[k*32 +: 32] = $urandom;
    return u;
  endfunction

  // Header model: the first NS beats of the current packet, zero beyond its length.
  function automatic segs_t model_segs();
    segs_t e = '0;
    for (int i = 0; i < pkt.size() && i < NS; i++) e[i*DW +: DW] = pkt[i];
    return e;
  endfunction

  function automatic int first_diff(input segs_t a, input segs_t b);
    for (int i = 0; i < NS; i++) if (a[i*DW +: DW] !== b[i*DW +: DW]) return i;
    return 0;
  endfunction

  function automatic void clear_mon();
    mon_segs.delete();
    mon_user.delete();
    mon_vlan.delete();
  endfunction

  task automatic send_packet(input int max_gap, input bit open_end, output int last_cyc);
    last_cyc = -1;
    for (int i = 0; i < pkt.size(); i++) begin
      int gap;
      int w;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      @(negedge axis_clk);
      repeat (gap) begin
        s_axis_tvalid = 1'b0;
        @(negedge axis_clk);
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = pkt[i];
      s_axis_tuser  = (i == 0) ? pkt_user : rand_user();
      s_axis_tlast  = !open_end && (i == pkt.size() - 1);
      w = 0;
      while (!s_axis_tready && w < 300) begin
        @(negedge axis_clk);
        w++;
      end
      if (!s_axis_tready) begin
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout beat %0d: tready=0, required 1", i);
        s_axis_tvalid = 1'b0;
        return;
      end
      last_cyc = cyc;
      @(posedge axis_clk);
    end
  endtask

  task automatic go_idle(input int n);
    @(negedge axis_clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (n) @(negedge axis_clk);
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(negedge axis_clk);
    n_tests++;
    if ({s_axis_tready, segs_valid, vlan_id_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b, required 000", {s_axis_tready, segs_valid, vlan_id_valid});
    end
    n_tests++;
    if (tdata_segs !== '0 || tuser_1st !== '0 || vlan_id !== '0) begin
      n_fail++;
      $display("FAIL reset_data: vlan %h tuser %h, required all zero", vlan_id, tuser_1st);
    end
    aresetn = 1'b1;
    @(negedge axis_clk);
    n_tests++;
    if (s_axis_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: tready %b, required 1", s_axis_tready);
    end
  endtask

  task automatic test_single_beat();
    beat_t b;
    segs_t e;
    int c;
    clear_mon();
    segs_ready = 1'b1;
    b = rand_beat();
    b[116 +: 12] = 12'h00A;
    pkt = '{b};
    pkt_user = 128'h5;
    e = model_segs();
    send_packet(0, 1'b0, c);
    @(negedge axis_clk);  // cycle 1
    s_axis_tvalid = 1'b0;
    n_tests++;
    if ({vlan_id_valid, vlan_id, s_axis_tready} !== {1'b1, 12'h00A, 1'b0}) begin
      n_fail++;
      $display("FAIL single_c1: vv %b vlan %h rdy %b, required 1 00a 0",
               vlan_id_valid, vlan_id, s_axis_tready);
    end
    @(negedge axis_clk);  // cycle 2
    n_tests++;
    if ({s_axis_tready, segs_valid, vlan_id_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL single_c2: rdy/sv/vv %b, required 000",
               {s_axis_tready, segs_valid, vlan_id_valid});
    end
    @(negedge axis_clk);  // cycle 3
    n_tests++;
    if ({segs_valid, s_axis_tready} !== 2'b10) begin
      n_fail++;
      $display("FAIL single_c3: sv/rdy %b, required 10", {segs_valid, s_axis_tready});
    end
    n_tests++;
    if (tdata_segs !== e) begin
      n_fail++;
      $display("FAIL single_segs seg %0d: got %h, required %h", first_diff(tdata_segs, e),
               tdata_segs[first_diff(tdata_segs, e)*DW +: DW],
               e[first_diff(tdata_segs, e)*DW +: DW]);
    end
    n_tests++;
    if (tuser_1st !== 128'h5) begin
      n_fail++;
      $display("FAIL single_tuser: got %h, required 5", tuser_1st);
    end
    @(negedge axis_clk);  // cycle 4
    n_tests++;
    if ({segs_valid, s_axis_tready, mon_segs.size() == 1} !== 3'b011) begin
      n_fail++;
      $display("FAIL single_c4: sv %b rdy %b pulses %0d, required 0 1 1",
               segs_valid, s_axis_tready, mon_segs.size());
    end
  endtask

  task automatic test_full_16();
    segs_t e;
    int c;
    int w;
    clear_mon();
    pkt.delete();
    for (int i = 0; i < NS; i++) pkt.push_back({8{32'(i)}});
    pkt_user = rand_user();
    e = model_segs();
    send_packet(1, 1'b0, c);
    @(negedge axis_clk);
    s_axis_tvalid = 1'b0;
    w = 0;
    while (!segs_valid && w < 50) begin
      @(negedge axis_clk);
      w++;
    end
    n_tests++;
    if (!segs_valid || cyc <= c + 1) begin
      n_fail++;
      $display("FAIL full16_pulse: sv %b at cycle %0d, last beat cycle %0d", segs_valid, cyc, c);
    end
    n_tests++;
    if (tdata_segs !== e || tuser_1st !== pkt_user) begin
      n_fail++;
      $display("FAIL full16_segs seg %0d: got %h, required %h", first_diff(tdata_segs, e),
               tdata_segs[first_diff(tdata_segs, e)*DW +: DW],
               e[first_diff(tdata_segs, e)*DW +: DW]);
    end
    @(negedge axis_clk);
    n_tests++;
    if (s_axis_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL full16_nodrain: tready %b, required 1", s_axis_tready);
    end
    repeat (10) @(negedge axis_clk);
    n_tests++;
    if (mon_segs.size() != 1 || mon_vlan.size() != 1) begin
      n_fail++;
      $display("FAIL full16_count: pulses %0d vlan pulses %0d, required 1 1",
               mon_segs.size(), mon_vlan.size());
    end
  endtask

  task automatic test_drain_20();
    segs_t e1, e2;
    logic [UW-1:0] u1, u2;
    logic [11:0] v1, v2;
    int c;
    clear_mon();
    pkt.delete();
    for (int i = 0; i < 20; i++) pkt.push_back(rand_beat());
    pkt_user = rand_user();
    e1 = model_segs();
    u1 = pkt_user;
    v1 = pkt[0][116 +: 12];
    send_packet(0, 1'b0, c);
    pkt = '{rand_beat(), rand_beat()};
    pkt_user = rand_user();
    e2 = model_segs();
    u2 = pkt_user;
    v2 = pkt[0][116 +: 12];
    send_packet(0, 1'b0, c);
    go_idle(15);
    n_tests++;
    if (mon_segs.size() != 2 || mon_vlan.size() != 2) begin
      n_fail++;
      $display("FAIL drain_count: pulses %0d vlan pulses %0d, required 2 2",
               mon_segs.size(), mon_vlan.size());
    end else begin
      n_tests++;
      if (mon_segs[0] !== e1 || mon_user[0] !== u1 || mon_vlan[0] !== v1) begin
        n_fail++;
        $display("FAIL drain_pkt1 seg %0d: got %h, required %h", first_diff(mon_segs[0], e1),
                 mon_segs[0][first_diff(mon_segs[0], e1)*DW +: DW],
                 e1[first_diff(mon_segs[0], e1)*DW +: DW]);
      end
      n_tests++;
      if (mon_segs[1] !== e2 || mon_user[1] !== u2 || mon_vlan[1] !== v2) begin
        n_fail++;
        $display("FAIL drain_pkt2 seg %0d: got %h, required %h", first_diff(mon_segs[1], e2),
                 mon_segs[1][first_diff(mon_segs[1], e2)*DW +: DW],
                 e2[first_diff(mon_segs[1], e2)*DW +: DW]);
      end
    end
  endtask

  task automatic test_backpressure();
    segs_t e;
    int c;
    clear_mon();
    segs_ready = 1'b0;
    pkt = '{rand_beat(), rand_beat(), rand_beat()};
    pkt_user = rand_user();
    e = model_segs();
    send_packet(3, 1'b0, c);
    for (int k = 1; k <= 10; k++) begin
      @(negedge axis_clk);
      s_axis_tvalid = 1'b0;
      n_tests++;
      if ({s_axis_tready, segs_valid} !== 2'b00) begin
        n_fail++;
        $display("FAIL stall_cycle %0d: rdy/sv %b, required 00", k, {s_axis_tready, segs_valid});
      end
    end
    segs_ready = 1'b1;
    @(negedge axis_clk);
    n_tests++;
    if (segs_valid !== 1'b1 || tdata_segs !== e) begin
      n_fail++;
      $display("FAIL stall_release: sv %b seg %0d got %h, required 1 %h", segs_valid,
               first_diff(tdata_segs, e), tdata_segs[first_diff(tdata_segs, e)*DW +: DW],
               e[first_diff(tdata_segs, e)*DW +: DW]);
    end
    repeat (5) @(negedge axis_clk);
    n_tests++;
    if (mon_segs.size() != 1) begin
      n_fail++;
      $display("FAIL stall_count: pulses %0d, required 1", mon_segs.size());
    end
  endtask

  task automatic test_back_to_back();
    segs_t e[2];
    logic [UW-1:0] u[2];
    logic [11:0] v[2];
    int c;
    clear_mon();
    segs_ready = 1'b1;
    for (int p = 0; p < 2; p++) begin
      pkt = '{rand_beat(), rand_beat()};
      pkt_user = rand_user();
      e[p] = model_segs();
      u[p] = pkt_user;
      v[p] = pkt[0][116 +: 12];
      send_packet(0, 1'b0, c);
    end
    go_idle(15);
    n_tests++;
    if (mon_segs.size() != 2 || mon_vlan.size() != 2) begin
      n_fail++;
      $display("FAIL b2b_count: pulses %0d vlan pulses %0d, required 2 2",
               mon_segs.size(), mon_vlan.size());
    end else begin
      for (int p = 0; p < 2; p++) begin
        n_tests++;
        if (mon_segs[p] !== e[p] || mon_user[p] !== u[p] || mon_vlan[p] !== v[p]) begin
          n_fail++;
          $display("FAIL b2b_pkt%0d: vlan %h tuser %h, required %h %h", p, mon_vlan[p],
                   mon_user[p], v[p], u[p]);
        end
      end
    end
  endtask

  task automatic test_random();
    segs_t e_q[$];
    logic [UW-1:0] u_q[$];
    logic [11:0] v_q[$];
    int c;
    int len;
    clear_mon();
    for (int p = 0; p < 6; p++) begin
      len = $urandom_range(22, 1);
      pkt.delete();
      for (int i = 0; i < len; i++) pkt.push_back(rand_beat());
      pkt_user = rand_user();
      e_q.push_back(model_segs());
      u_q.push_back(pkt_user);
      v_q.push_back(pkt[0][116 +: 12]);
      send_packet(2, 1'b0, c);
    end
    go_idle(20);
    n_tests++;
    if (mon_segs.size() != e_q.size()) begin
      n_fail++;
      $display("FAIL rand_count: pulses %0d, required %0d", mon_segs.size(), e_q.size());
    end else begin
      for (int p = 0; p < e_q.size(); p++) begin
        n_tests++;
        if (mon_segs[p] !== e_q[p] || mon_user[p] !== u_q[p] || mon_vlan[p] !== v_q[p]) begin
          n_fail++;
          $display("FAIL rand_pkt%0d seg %0d: got %h, required %h", p,
                   first_diff(mon_segs[p], e_q[p]),
                   mon_segs[p][first_diff(mon_segs[p], e_q[p])*DW +: DW],
                   e_q[p][first_diff(mon_segs[p], e_q[p])*DW +: DW]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_fill();
    segs_t e;
    int c;
    pkt.delete();
    for (int i = 0; i < 5; i++) pkt.push_back(rand_beat());
    pkt_user = rand_user();
    send_packet(0, 1'b1, c);
    @(negedge axis_clk);
    aresetn = 1'b0;
    s_axis_tvalid = 1'b0;
    @(negedge axis_clk);
    n_tests++;
    if ({s_axis_tready, segs_valid, vlan_id_valid} !== 3'b000 || tdata_segs !== '0 ||
        tuser_1st !== '0 || vlan_id !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: rdy/sv/vv %b vlan %h, required 000 000",
               {s_axis_tready, segs_valid, vlan_id_valid}, vlan_id);
    end
    aresetn = 1'b1;
    clear_mon();
    @(negedge axis_clk);
    n_tests++;
    if (s_axis_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_ready: tready %b, required 1", s_axis_tready);
    end
    pkt = '{rand_beat(), rand_beat()};
    pkt_user = rand_user();
    e = model_segs();
    send_packet(0, 1'b0, c);
    go_idle(10);
    n_tests++;
    if (mon_segs.size() != 1) begin
      n_fail++;
      $display("FAIL midreset_count: pulses %0d, required 1", mon_segs.size());
    end else begin
      n_tests++;
      if (mon_segs[0] !== e || mon_user[0] !== pkt_user || mon_vlan[0] !== pkt[0][116 +: 12])
      begin
        n_fail++;
        $display("FAIL midreset_pkt seg %0d: got %h, required %h", first_diff(mon_segs[0], e),
                 mon_segs[0][first_diff(mon_segs[0], e)*DW +: DW],
                 e[first_diff(mon_segs[0], e)*DW +: DW]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_full_16();
    test_drain_20();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid_fill();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/parser_wait_segs.md
Name: parser_wait_segs

Overview:
- Front end of the parser. Accepts the 256b AXI-Stream packet and captures its first C_NUM_SEGS beats into one flat header vector (tdata_segs) together with the first-beat tuser.
- Presents the VLAN ID early as the parse-action RAM address, then hands the captured vector to the parsing stage with a one-cycle segs_valid pulse.
- Discards any beats beyond C_NUM_SEGS. The payload path is separate and not handled here.

Parameters:
- C_AXIS_DATA_WIDTH, 256, stream data width.
- C_AXIS_TUSER_WIDTH, 128, tuser width.
- C_NUM_SEGS, 16, max beats captured per packet.
- C_VLANID_WIDTH, 12, VLAN ID width.
- C_RAM_LAT, 2, cycles from vlan_id_valid until the parse-action RAM output is valid.

Ports:
- axis_clk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- s_axis_tdata  in  256  packet data
- s_axis_tuser  in  128  metadata, meaningful on first beat only
- s_axis_tkeep  in  32  byte enables, ignored (full beats are stored)
- s_axis_tvalid  in  1  beat valid
- s_axis_tlast  in  1  last beat of packet
- s_axis_tready  out  1  beat accept
- tdata_segs  out  C_NUM_SEGS*256  captured header; segment k at [k*256 +: 256]
- tuser_1st  out  128  tuser of first beat
- segs_valid  out  1  one-cycle pulse: tdata_segs/tuser_1st valid
- segs_ready  in  1  parsing stage idle and able to sample
- vlan_id  out  12  parse-action RAM address
- vlan_id_valid  out  1  one-cycle pulse when vlan_id updates

Behaviour:
- Reset: already decided, aresetn synchronous active-low on axis_clk. All outputs 0, state IDLE, seg_cnt 0, drain_pending 0. Reset mid-packet abandons the packet. Beats of that packet arriving after reset are treated as a new packet (no resync).
- Beat accepted only when s_axis_tvalid && s_axis_tready.
- All outputs are registered.

- IDLE (tready=1). On an accepted beat:
  - seg0 <= tdata; segs 1..C_NUM_SEGS-1 <= 0.
  - tuser_1st <= tuser.
  - vlan_id <= tdata[116+:12]; vlan_id_valid pulses 1 cycle.
  - seg_cnt <= 1; lat_cnt <= 0.
  - If tlast, go WAIT_RAM (drain_pending=0); else go FILL.
- FILL (tready=1). On an accepted beat:
  - seg[seg_cnt] <= tdata; seg_cnt++.
  - If tlast, go WAIT_RAM with drain_pending=0.
  - Else if seg_cnt==C_NUM_SEGS-1, go WAIT_RAM with drain_pending=1.
- WAIT_RAM (tready=0). Stay until at least C_RAM_LAT cycles have elapsed since the vlan_id_valid pulse (lat_cnt counts every cycle from first-beat accept, saturating), then go EMIT.
- EMIT (tready=0). Wait for segs_ready=1; in that cycle drive segs_valid=1 for exactly one cycle. Next state is DRAIN if drain_pending, else IDLE.
- DRAIN (tready=1). Discard accepted beats; on an accepted beat with tlast, go IDLE.

- Stability: tdata_segs and tuser_1st hold from the segs_valid pulse until the next first-beat accept, which is at least 1 cycle after the pulse.
- Latency:
  - 1-beat packet: first-beat accept at cycle 0 gives segs_valid at the earliest in cycle C_RAM_LAT+1.
  - N-beat packet: segs_valid is no earlier than 1 cycle after the last captured beat.
- Exactly C_NUM_SEGS beats with tlast on beat C_NUM_SEGS: no drain (tlast wins over the count limit).
- segs_ready held low: the block stalls in EMIT indefinitely with tready=0 (backpressure).
- tvalid gaps inside a packet: the block waits in FILL/DRAIN; no timeout.
- seg_cnt width is clog2(C_NUM_SEGS)+1; it never wraps.

Test Plan:
- 1-beat packet with tdata[116+:12]=12'h00A and tuser=128'h5 -> vlan_id=0x00A pulse at cycle 1; segs_valid at cycle 3 (C_RAM_LAT=2, segs_ready=1); seg0=beat, segs1-15=0; tuser_1st=0x5; tready low in cycles 2-3.
- 16-beat packet, beat i = {8{32'h(i)}} -> segs_valid once; seg k = beat k for all 16; no DRAIN entered; tready=1 on the next cycle.
- 20-beat packet -> segs 0-15 captured; beats 16-19 accepted and discarded in DRAIN; next packet's seg0 is its own first beat.
- 3-beat packet with segs_ready=0 for 10 cycles -> tready=0 and segs_valid=0 throughout the stall; single pulse in the cycle segs_ready rises; segs 3-15=0.
- Back-to-back 2-beat packets with tvalid continuously high -> two segs_valid pulses; second packet's tdata_segs/vlan_id/tuser_1st fully replace the first's, with no stale segments.
- aresetn low for 1 cycle during FILL at seg_cnt=5 -> all outputs 0, state IDLE; a fresh packet afterwards is captured correctly from seg0.
